dx_hazard_controller: RTL and testbench

//  Controls the D->X stage boundary. It sits beside the D/X pipeline register,

---
 rtl/dx_hazard_controller.sv | 157 +++++++++++++++
 tb/tb_dx_hazard_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dx_hazard_controller.sv
// dx_hazard_controller
// Decides the stall and flush controls at the D->X boundary of the pipeline.
// It detects load-use hazards between the instruction in decode and a load
// held in the D/X register, and it handles redirects (a taken branch or a
// jump) resolved in X. It also keeps saturating performance counters.
//
// Parameters:
//   LOAD_STALL    bubble cycles inserted per load-use hazard (1..15)
//   CNT_W         width of the performance counters
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   d_*           register usage of the instruction in decode
//   x_*           destination info of the D/X instruction, and the X redirect
//   pc_write_en   PC may update
//   fd_write_en   F/D register may load
//   fd_flush      F/D loads a NOP
//   dx_bubble     D/X loads zero controls
//   stall_cycles  saturating count of stall (bubble) cycles
//   flush_events  saturating count of accepted redirects
// The four control outputs are combinational, so a hazard stalls in the same
// cycle it is seen.
module dx_hazard_controller #(
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs_addr,
  input  logic [4:0]       d_rt_addr,
  input  logic             d_uses_rs,
  input  logic             d_uses_rt,
  input  logic             x_mem_read,
  input  logic             x_reg_write,
  input  logic             x_reg_dst,
  input  logic [4:0]       x_rt_addr,
  input  logic [4:0]       x_rd_addr,
  input  logic             x_redirect,
  output logic             pc_write_en,
  output logic             fd_write_en,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned CNT_BITS = 4;
  // A single-cycle stall never needs the STALL state.
  localparam logic MULTI_STALL = (LOAD_STALL > 1);
  localparam logic [CNT_BITS-1:0] STALL_RELOAD = CNT_BITS'(LOAD_STALL - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_cycles_q, flush_events_q;

  logic [4:0] x_dest;
  logic       hz;
  logic       stall_c;

  // Load-use detection; r0 is hardwired, so it never creates a dependency.
  always_comb begin
    x_dest = x_reg_dst ? x_rd_addr : x_rt_addr;
    hz = x_mem_read && x_reg_write && (x_dest != 5'd0) &&
         ((d_uses_rs && (d_rs_addr == x_dest)) ||
          (d_uses_rt && (d_rt_addr == x_dest)));
  end

  // State register and stall down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control outputs; a redirect overrides any stall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_c     = 1'b0;
    pc_write_en = 1'b1;
    fd_write_en = 1'b1;
    fd_flush    = 1'b0;
    dx_bubble   = 1'b0;

    if (x_redirect) begin
      fd_flush  = 1'b1;
      dx_bubble = 1'b1;
      state_d   = ST_RUN;
      cnt_d     = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz) begin
            stall_c = 1'b1;
            if (MULTI_STALL) begin
              cnt_d   = STALL_RELOAD;
              state_d = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          // Hazard is not re-checked here: the load has not moved yet.
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_BITS'(1);
          if (cnt_q <= CNT_BITS'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end

    if (stall_c) begin
      pc_write_en = 1'b0;
      fd_write_en = 1'b0;
      dx_bubble   = 1'b1;
    end

    // Hold the front end quiet and fill the pipe with NOPs during reset.
    if (rst) begin
      pc_write_en = 1'b0;
      fd_write_en = 1'b0;
      fd_flush    = 1'b1;
      dx_bubble   = 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (stall_c && (stall_cycles_q != {CNT_W{1'b1}})) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
      if (x_redirect && (flush_events_q != {CNT_W{1'b1}})) begin
        flush_events_q <= flush_events_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_dx_hazard_controller.sv
// Directed bench for dx_hazard_controller. Three instances share stimulus:
// LOAD_STALL=1, LOAD_STALL=3, and LOAD_STALL=1 with 4-bit counters.
// Control outputs are compared as {pc_write_en, fd_write_en, fd_flush, dx_bubble}.
module tb_dx_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] d_rs_addr, d_rt_addr, x_rt_addr, x_rd_addr;
  logic       d_uses_rs, d_uses_rt, x_mem_read, x_reg_write, x_reg_dst, x_redirect;

  logic        a_pc, a_fd, a_fl, a_bb;
  logic        b_pc, b_fd, b_fl, b_bb;
  logic        c_pc, c_fd, c_fl, c_bb;
  logic [15:0] a_sc, a_fe, b_sc, b_fe;
  logic [3:0]  c_sc, c_fe;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] O_RESET  = 4'b0011;
  localparam logic [3:0] O_NORMAL = 4'b1100;
  localparam logic [3:0] O_STALL  = 4'b0001;
  localparam logic [3:0] O_REDIR  = 4'b1111;

  always #5 clk = ~clk;

  dx_hazard_controller #(.LOAD_STALL(1), .CNT_W(16)) u_ls1 (
    .clk(clk), .rst(rst), .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .x_mem_read(x_mem_read),
    .x_reg_write(x_reg_write), .x_reg_dst(x_reg_dst), .x_rt_addr(x_rt_addr),
    .x_rd_addr(x_rd_addr), .x_redirect(x_redirect),
    .pc_write_en(a_pc), .fd_write_en(a_fd), .fd_flush(a_fl), .dx_bubble(a_bb),
    .stall_cycles(a_sc), .flush_events(a_fe));

  dx_hazard_controller #(.LOAD_STALL(3), .CNT_W(16)) u_ls3 (
    .clk(clk), .rst(rst), .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .x_mem_read(x_mem_read),
    .x_reg_write(x_reg_write), .x_reg_dst(x_reg_dst), .x_rt_addr(x_rt_addr),
    .x_rd_addr(x_rd_addr), .x_redirect(x_redirect),
    .pc_write_en(b_pc), .fd_write_en(b_fd), .fd_flush(b_fl), .dx_bubble(b_bb),
    .stall_cycles(b_sc), .flush_events(b_fe));

  dx_hazard_controller #(.LOAD_STALL(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .x_mem_read(x_mem_read),
    .x_reg_write(x_reg_write), .x_reg_dst(x_reg_dst), .x_rt_addr(x_rt_addr),
    .x_rd_addr(x_rd_addr), .x_redirect(x_redirect),
    .pc_write_en(c_pc), .fd_write_en(c_fd), .fd_flush(c_fl), .dx_bubble(c_bb),
    .stall_cycles(c_sc), .flush_events(c_fe));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_rs_addr = '0; d_rt_addr = '0; d_uses_rs = 0; d_uses_rt = 0;
    x_mem_read = 0; x_reg_write = 0; x_reg_dst = 0;
    x_rt_addr = '0; x_rd_addr = '0; x_redirect = 0;
  endtask

  // Load into r5 (rt destination) followed by a consumer of r5 via rs.
  task automatic set_hazard();
    x_mem_read = 1; x_reg_write = 1; x_reg_dst = 0; x_rt_addr = 5'd5;
    d_rs_addr = 5'd5; d_uses_rs = 1;
  endtask

  initial begin
    clear_inputs();
    rst = 1;

    // Reset
    tick(); tick();
    chk("rst_out_ls1", {a_pc, a_fd, a_fl, a_bb}, O_RESET);
    chk("rst_out_ls3", {b_pc, b_fd, b_fl, b_bb}, O_RESET);
    rst = 0;
    #1;
    chk("post_rst_out", {a_pc, a_fd, a_fl, a_bb}, O_NORMAL);
    chk("post_rst_sc", a_sc, 0);
    chk("post_rst_fe", b_fe, 0);
    chk("post_rst_sat", {c_sc, c_fe}, 0);

    // Load-use, LOAD_STALL=1 and =3
    set_hazard(); #1;
    chk("lu_c0_ls1", {a_pc, a_fd, a_fl, a_bb}, O_STALL);
    chk("lu_c0_ls3", {b_pc, b_fd, b_fl, b_bb}, O_STALL);
    tick(); clear_inputs(); #1;
    chk("lu_c1_ls1", {a_pc, a_fd, a_fl, a_bb}, O_NORMAL);
    chk("lu_sc_ls1", a_sc, 1);
    chk("lu_c1_ls3", {b_pc, b_fd, b_fl, b_bb}, O_STALL);
    tick(); #1;
    chk("lu_c2_ls3", {b_pc, b_fd, b_fl, b_bb}, O_STALL);
    tick(); #1;
    chk("lu_c3_ls3", {b_pc, b_fd, b_fl, b_bb}, O_NORMAL);
    chk("lu_sc_ls3", b_sc, 3);
    chk("lu_sc_sat", c_sc, 1);

    // No-stall cases
    set_hazard(); x_rt_addr = 5'd0; d_rs_addr = 5'd0; #1;
    chk("ns_r0_ls1", {a_pc, a_fd, a_fl, a_bb}, O_NORMAL);
    chk("ns_r0_ls3", {b_pc, b_fd, b_fl, b_bb}, O_NORMAL);
    set_hazard(); d_uses_rs = 0; #1;
    chk("ns_nouse", {a_pc, a_fd, a_fl, a_bb}, O_NORMAL);
    set_hazard(); x_mem_read = 0; #1;
    chk("ns_noload", {a_pc, a_fd, a_fl, a_bb}, O_NORMAL);
    set_hazard(); x_reg_write = 0; #1;
    chk("ns_nowrite", {a_pc, a_fd, a_fl, a_bb}, O_NORMAL);

    // rd destination matched through rt of the decode instruction
    clear_inputs();
    x_mem_read = 1; x_reg_write = 1; x_reg_dst = 1; x_rd_addr = 5'd7; x_rt_addr = 5'd3;
    d_rt_addr = 5'd7; d_uses_rt = 1; d_rs_addr = 5'd3; #1;
    chk("rd_hz_ls1", {a_pc, a_fd, a_fl, a_bb}, O_STALL);
    tick(); clear_inputs();
    tick(); tick(); #1;
    chk("rd_sc_ls1", a_sc, 2);
    chk("rd_sc_ls3", b_sc, 6);

    // Hazard and redirect together: redirect wins
    set_hazard(); x_redirect = 1; #1;
    chk("rdr_same_ls3", {b_pc, b_fd, b_fl, b_bb}, O_REDIR);
    chk("rdr_same_ls1", {a_pc, a_fd, a_fl, a_bb}, O_REDIR);
    tick(); clear_inputs(); #1;
    chk("rdr_same_next", {b_pc, b_fd, b_fl, b_bb}, O_NORMAL);
    chk("rdr_same_fe", b_fe, 1);
    chk("rdr_same_sc", b_sc, 6);

    // Redirect in stall cycle 2 of 3 cancels the stall
    set_hazard(); tick();
    clear_inputs(); x_redirect = 1; #1;
    chk("rdr_mid_ls3", {b_pc, b_fd, b_fl, b_bb}, O_REDIR);
    tick(); x_redirect = 0; #1;
    chk("rdr_mid_next", {b_pc, b_fd, b_fl, b_bb}, O_NORMAL);
    chk("rdr_mid_fe", b_fe, 2);
    chk("rdr_mid_sc", b_sc, 7);
    chk("rdr_mid_sc1", a_sc, 3);

    // Saturation on 4-bit counters (starts at 3)
    set_hazard();
    for (int i = 0; i < 11; i++) tick();
    chk("sat_14", c_sc, 14);
    for (int i = 0; i < 9; i++) tick();
    chk("sat_hold", c_sc, 15);
    chk("sat_ls1_16b", a_sc, 23);
    chk("sat_ls3_16b", b_sc, 27);
    chk("sat_fe", c_fe, 2);

    // Reset asserted in the middle of a 3-cycle stall
    clear_inputs(); tick(); tick(); tick();
    set_hazard(); tick();
    clear_inputs(); #1;
    chk("mid_stall_pre", {b_pc, b_fd, b_fl, b_bb}, O_STALL);
    rst = 1; #1;
    chk("mid_stall_rst", {b_pc, b_fd, b_fl, b_bb}, O_RESET);
    tick(); rst = 0; #1;
    chk("mid_stall_run", {b_pc, b_fd, b_fl, b_bb}, O_NORMAL);
    chk("mid_stall_cnt", {b_sc, b_fe}, 0);
    chk("mid_stall_sat", {c_sc, c_fe}, 0);
    tick(); #1;
    chk("mid_stall_idle", {b_pc, b_fd, b_fl, b_bb}, O_NORMAL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
